spi_tx_fifo: RTL and testbench

- Show-ahead (first-word-fall-through) 9-bit sample FIFO directly upstream of the SPI transmitter.
- Buffers 9-bit words from the producer stage and presents the head word continuously on rd_data.
- Pops one word per rising edge of the transmitter's single-cycle refresh strobe.
- Shares the transmitter's sclk net as clk. This block updates on posedge; the transmitter samples on negedge, which gives half a cycle of setup.

---
 rtl/spi_tx_fifo.sv | 117 +++++++++++
 tb/tb_spi_tx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo.sv
// Show-ahead 9-bit sample FIFO feeding the SPI transmitter; pops on the rising edge of rd_req.
// Optional high-water-mark output enabled by defining SPI_TX_FIFO_HWM_EN.
module spi_tx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          almost_full,
  input  logic          rd_req,
  output logic [8:0]    rd_data,
  output logic          empty,
  output logic          data_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_overflow
`ifdef SPI_TX_FIFO_HWM_EN
  ,
  output logic [AW:0]   hwm
`endif
);

  localparam int LVL_W = AW + 1;

  logic [8:0]       mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             overflow_q, overflow_d;
  logic             rd_req_q, rd_req_d;
  logic             pop_evt, push, pop;

  always_comb begin
    rd_req_d   = rd_req;
    pop_evt    = rd_req & ~rd_req_q;
    // Full/empty are the pre-edge flags, so a push into a full FIFO is dropped even if a pop frees a slot.
    push       = wr_en & ~full_q;
    pop        = pop_evt & ~empty_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (wr_en & full_q)    overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;

    if (reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end

    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
    afull_d = (level_d >= LVL_W'(AFULL_TH));
  end

  always_ff @(posedge clk) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    level_q    <= level_d;
    full_q     <= full_d;
    empty_q    <= empty_d;
    afull_q    <= afull_d;
    overflow_q <= overflow_d;
    rd_req_q   <= rd_req_d;
  end

  // Storage is not cleared by reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data     = mem[rd_ptr_q];
  assign level       = level_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign data_ready  = ~empty_q;
  assign almost_full = afull_q;
  assign overflow    = overflow_q;

`ifdef SPI_TX_FIFO_HWM_EN
  logic [LVL_W-1:0] hwm_q, hwm_d;

  // A clear restarts tracking from the post-update level, so a coincident push is still counted.
  always_comb begin
    hwm_d = (level_d > hwm_q) ? level_d : hwm_q;
    if (clr_overflow) hwm_d = level_d;
    if (reset)        hwm_d = '0;
  end

  always_ff @(posedge clk) begin
    hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed bench for spi_tx_fifo (DEPTH=8) with a queue-based reference model checked every cycle.
module tb_spi_tx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [8:0]   wr_data;
  logic         wr_en;
  logic         full, almost_full;
  logic         rd_req;
  logic [8:0]   rd_data;
  logic         empty, data_ready;
  logic [AW:0]  level;
  logic         overflow;
  logic         clr_overflow;
`ifdef SPI_TX_FIFO_HWM_EN
  logic [AW:0]  hwm;
`endif

  spi_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .almost_full(almost_full), .rd_req(rd_req), .rd_data(rd_data),
    .empty(empty), .data_ready(data_ready), .level(level), .overflow(overflow),
    .clr_overflow(clr_overflow)
`ifdef SPI_TX_FIFO_HWM_EN
    , .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the sticky/peak bookkeeping.
  int q[$];
  bit m_ovf, m_rdprev, m_ok;
  int m_hwm;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf    = 0;
      m_hwm    = 0;
      m_rdprev = rd_req;
      m_ok     = 1;
    end else if (m_ok) begin
      bit pe, was_full, was_empty;
      pe        = rd_req && !m_rdprev;
      m_rdprev  = rd_req;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (pe && !was_empty) void'(q.pop_front());
      if (wr_en && !was_full) q.push_back(int'(wr_data));
      if (wr_en && was_full) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
      if (clr_overflow) m_hwm = q.size();
      else if (q.size() > m_hwm) m_hwm = q.size();
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_level", 32'(level), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_ready", 32'(data_ready), 32'(q.size() != 0));
      chk("m_full", 32'(full), 32'(q.size() == DEPTH));
      chk("m_afull", 32'(almost_full), 32'(q.size() >= DEPTH - 2));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) chk("m_rd_data", 32'(rd_data), 32'(q[0]));
`ifdef SPI_TX_FIFO_HWM_EN
      chk("m_hwm", 32'(hwm), 32'(m_hwm));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [8:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop1();
    rd_req = 1'b1; tick();
    rd_req = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_req = 1'b0; clr_overflow = 1'b0;
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single word, strobe held five cycles pops once.
    push1(9'h1A5);
    chk("w1_empty", 32'(empty), 32'd0);
    chk("w1_data", 32'(rd_data), 32'h1A5);
    chk("w1_level", 32'(level), 32'd1);
    push1(9'h0AA);
    rd_req = 1'b1;
    repeat (5) tick();
    chk("hold_level", 32'(level), 32'd1);
    chk("hold_data", 32'(rd_data), 32'h0AA);
    rd_req = 1'b0; tick();
    pop1();
    chk("hold_empty", 32'(empty), 32'd1);

    // Fill to full, overflow on the ninth write.
    for (int k = 0; k < DEPTH; k++) begin
      push1(9'(k));
      chk("fill_afull", 32'(almost_full), 32'(k + 1 >= 6));
    end
    chk("fill_full", 32'(full), 32'd1);
    push1(9'h1FF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_data", 32'(rd_data), 32'(k));
      pop1();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous write and pop edge.
    for (int k = 0; k < DEPTH; k++) push1(9'h100 + 9'(k));
    wr_en = 1'b1; wr_data = 9'h1EE; rd_req = 1'b1;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    chk("fp_level", 32'(level), 32'd7);
    chk("fp_ovf", 32'(overflow), 32'd1);
    chk("fp_data", 32'(rd_data), 32'h101);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("fp_clr", 32'(overflow), 32'd0);

    // Reset mid-operation, then push with a pop edge into the empty FIFO.
    do_reset();
    chk("mid_rst_level", 32'(level), 32'd0);
    wr_en = 1'b1; wr_data = 9'h055; rd_req = 1'b1;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    chk("ep_level", 32'(level), 32'd1);
    chk("ep_data", 32'(rd_data), 32'h055);
    tick();
    pop1();
    chk("ep_drained", 32'(empty), 32'd1);

    // Strobe held high across reset release must not pop.
    rd_req = 1'b1;
    do_reset();
    push1(9'h011); push1(9'h022); push1(9'h033);
    tick();
    chk("rh_level", 32'(level), 32'd3);
    chk("rh_data", 32'(rd_data), 32'h011);
    rd_req = 1'b0; tick();
    rd_req = 1'b1; tick();
    chk("rh_pop_level", 32'(level), 32'd2);
    chk("rh_pop_data", 32'(rd_data), 32'h022);
    rd_req = 1'b0; tick();

`ifdef SPI_TX_FIFO_HWM_EN
    do_reset();
    for (int k = 0; k < 5; k++) push1(9'h0C0 + 9'(k));
    repeat (3) pop1();
    push1(9'h0CF);
    chk("hwm_peak", 32'(hwm), 32'd5);
    chk("hwm_level", 32'(level), 32'd3);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("hwm_clr", 32'(hwm), 32'd3);
    do_reset();
    chk("hwm_rst", 32'(hwm), 32'd0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
